// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-access stage: load/store over req/gnt/rvalid bus, write-back to mem_wb
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        lat_we;
    logic        lat_rwe;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;
    logic [4:0]  lat_waddr;
    logic [31:0] cap_data;
    logic        err_flag;
    logic [15:0] cnt;
    logic        misaligned;
    logic        accept;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (mem_req_i) begin
            case (mem_funct3_i)
                3'b000, 3'b100: misaligned = 1'b0;
                3'b001, 3'b101: misaligned = mem_addr_i[0];
                default:        misaligned = (mem_addr_i[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign accept = (state == IDLE) && mem_req_i && !misaligned;

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = mem_wdata_i;
        case (mem_funct3_i)
            3'b000, 3'b100: begin
                be_nxt    = 4'b0001 << mem_addr_i[1:0];
                wdata_nxt = {4{mem_wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                be_nxt    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = mem_wdata_i;
            end
        endcase
    end

    // Lane select uses the offset latched at accept; ex_mem may not change under us, but it is not relied on.
    assign rd_shift = bus_rdata_i >> {lat_off, 3'b000};
    assign rd_half  = lat_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        case (lat_f3)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_data = {24'h0, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_data = {16'h0, rd_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            bus_be_o    <= 4'h0;
            lat_we      <= 1'b0;
            lat_rwe     <= 1'b0;
            lat_f3      <= 3'h0;
            lat_off     <= 2'h0;
            lat_waddr   <= 5'h0;
            cap_data    <= 32'h0;
            err_flag    <= 1'b0;
            cnt         <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we      <= mem_we_i;
                        lat_rwe     <= reg_we_i;
                        lat_f3      <= mem_funct3_i;
                        lat_off     <= mem_addr_i[1:0];
                        lat_waddr   <= reg_waddr_i;
                        cap_data    <= 32'h0;
                        err_flag    <= 1'b0;
                        cnt         <= 16'h0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_wdata_o <= wdata_nxt;
                        bus_be_o    <= be_nxt;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state     <= bus_we_o ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        cap_data <= ld_data;
                        cnt      <= 16'h0;
                        state    <= DONE;
                    end else if (cnt == TO_LAST) begin
                        cap_data <= 32'h0;
                        err_flag <= 1'b1;
                        cnt      <= 16'h0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 16'h1;
                    end
                end
                DONE: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset also forces the combinational pass-through path to zero.
    always_comb begin
        stall_o     = 1'b0;
        bus_err_o   = 1'b0;
        misalign_o  = 1'b0;
        reg_wdata_o = 32'h0;
        reg_we_o    = 1'b0;
        reg_waddr_o = 5'h0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (!mem_req_i) begin
                        reg_wdata_o = reg_wdata_i;
                        reg_we_o    = reg_we_i;
                        reg_waddr_o = reg_waddr_i;
                    end else if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                REQ, WAIT: stall_o = 1'b1;
                DONE: begin
                    reg_wdata_o = cap_data;
                    reg_waddr_o = lat_waddr;
                    reg_we_o    = lat_rwe && !lat_we;
                    bus_err_o   = err_flag;
                end
                default: stall_o = 1'b0;
            endcase
        end
    end
endmodule
